// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: synchronises the Gray write pointer,
// issues registered-memory reads and streams words out through a 2-entry skid buffer.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int PTR_WIDTH   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [PTR_WIDTH:0]    g_wptr,
    output logic [PTR_WIDTH:0]    b_rptr,
    output logic [PTR_WIDTH:0]    g_rptr,
    output logic                  r_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  empty,
    output logic [PTR_WIDTH:0]    rd_level
);

    localparam int PW = PTR_WIDTH + 1;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PW-1:0]         sync_q [SYNC_STAGES];
    logic [PW-1:0]         g_wptr_sync;
    logic [PW-1:0]         b_rptr_q, b_rptr_d;
    logic [PW-1:0]         g_rptr_q, g_rptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  infl_q, infl_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  deq;
    logic [2:0]            occ_after;
    logic [1:0]            cnt_pop;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= g_wptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign g_wptr_sync = sync_q[SYNC_STAGES-1];
    assign empty       = (g_wptr_sync == g_rptr_q);
    assign rd_level    = gray2bin(g_wptr_sync) - b_rptr_q;
    assign rvalid      = (cnt_q != 2'd0);
    assign rdata       = buf0_q;
    assign b_rptr      = b_rptr_q;
    assign g_rptr      = g_rptr_q;
    assign deq         = rvalid && rready;

    // A read is only issued if, after this cycle's dequeue, the buffer still has room for it.
    assign occ_after = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, deq};
    assign r_en      = !empty && (occ_after < 3'd2);
    assign cnt_pop   = cnt_q - {1'b0, deq};

    always_comb begin
        b_rptr_d = b_rptr_q;
        g_rptr_d = g_rptr_q;
        infl_d   = r_en;
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        cnt_d    = cnt_pop + {1'b0, infl_q};

        if (r_en) begin
            b_rptr_d = b_rptr_q + 1'b1;
            g_rptr_d = bin2gray(b_rptr_q + 1'b1);
        end

        // Pop first, then append the arriving word behind whatever remains.
        if (deq) begin
            buf0_d = buf1_q;
        end
        if (infl_q) begin
            if (cnt_pop == 2'd0) begin
                buf0_d = mem_rdata;
            end else begin
                buf1_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            b_rptr_q <= '0;
            g_rptr_q <= '0;
            cnt_q    <= '0;
            infl_q   <= 1'b0;
            buf0_q   <= '0;
            buf1_q   <= '0;
        end else begin
            b_rptr_q <= b_rptr_d;
            g_rptr_q <= g_rptr_d;
            cnt_q    <= cnt_d;
            infl_q   <= infl_d;
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
        end
    end

endmodule
